// File: rtl/onchip_mem_block_reader.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_block_reader
// Description : Streams a block of 32-bit words from a 1-cycle-latency on-chip
//               memory into a small valid/ready output FIFO. An optional
//               running checksum is enabled by ONCHIP_MEM_READER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_block_reader #(
    parameter int MEM_WORDS  = 2250,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [11:0] base_addr,
    input  logic [12:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic        mem_clken,
    input  logic [31:0] mem_readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] checksum
);

    localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [12:0]        c_MEM_WORDS = 13'(MEM_WORDS);
    localparam logic [11:0]        c_LAST_ADDR = 12'(MEM_WORDS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [11:0]        r_addr;
    logic [12:0]        r_remaining;
    logic               r_inflight;
    logic               r_err;
    logic [31:0]        r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_occupancy;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_start_idle;
    logic               w_bad_base;

    // A read may only issue if its data is guaranteed a free FIFO slot.
    assign w_occupancy  = r_count + {{(c_CNT_W-1){1'b0}}, r_inflight};
    assign w_issue      = (r_state == c_READ) && (w_occupancy < c_DEPTH);
    assign w_push       = r_inflight;
    assign w_pop        = out_valid && out_ready;
    assign w_start_idle = (r_state == c_IDLE) && start;
    assign w_bad_base   = ({1'b0, base_addr} >= c_MEM_WORDS);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    if ((word_count == 13'd0) || w_bad_base) begin
                        w_next_state = c_DONE;
                    end else begin
                        w_next_state = c_READ;
                    end
                end
            end
            c_READ: begin
                if (w_issue && (r_remaining == 13'd1)) begin
                    w_next_state = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if ((r_count == '0) && !r_inflight) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        case (r_state)
            c_READ, c_DRAIN: busy = 1'b1;
            c_DONE: begin
                done = 1'b1;
                err  = r_err;
            end
            default: ;
        endcase
    end

    assign mem_chipselect = w_issue;
    assign mem_address    = r_addr;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    // Request latch, address walk and FIFO bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_err       <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_start_idle) begin
                r_addr      <= base_addr;
                r_remaining <= word_count;
                r_err       <= (word_count != 13'd0) && w_bad_base;
            end else if (w_issue) begin
                r_addr      <= (r_addr == c_LAST_ADDR) ? 12'd0 : r_addr + 12'd1;
                r_remaining <= r_remaining - 13'd1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: ;
            endcase
        end
    end

    // FIFO storage needs no reset; r_count gates its visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_readdata;
        end
    end

    assign out_data  = r_fifo[r_rd_ptr];
    assign out_valid = (r_count != '0);

`ifdef ONCHIP_MEM_READER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= '0;
        end else if (w_start_idle) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + out_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'd0;
`endif

endmodule
`default_nettype wire
